// File: rtl/ni_flit_injector.sv
// ni_flit_injector: packetises requests into head/body/tail flits on a credit-managed VC of the router local port.
module ni_flit_injector #(
   parameter int V            = 4,
   parameter int B            = 4,
   parameter int NX           = 8,
   parameter int NY           = 8,
   parameter int C            = 2,
   parameter int Fpay         = 32,
   parameter int MAX_PCK_SIZE = 16,
   localparam int Xw   = (NX > 1) ? $clog2(NX) : 1,
   localparam int Yw   = (NY > 1) ? $clog2(NY) : 1,
   localparam int Cw   = (C > 1) ? $clog2(C) : 1,
   localparam int Fw   = 2 + V + Fpay,
   localparam int Sw   = $clog2(MAX_PCK_SIZE + 1),
   localparam int CNTw = $clog2(B + 1),
   localparam int Vw   = (V > 1) ? $clog2(V) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [Xw-1:0] current_x,
   input  logic [Yw-1:0] current_y,
   input  logic          pck_req,
   input  logic [Xw-1:0] pck_dest_x,
   input  logic [Yw-1:0] pck_dest_y,
   input  logic [Cw-1:0] pck_class,
   input  logic [Sw-1:0] pck_size,
   output logic          pck_ack,
   output logic          pck_done,
   output logic [Fw-1:0] flit_out,
   output logic          flit_out_we,
   input  logic [V-1:0]  credit_in
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t r_state, w_state_nxt;
   logic [CNTw-1:0] r_cnt [V];
   logic [Vw-1:0] r_vc, w_vc_nxt, w_sel;
   logic w_any;
   logic [Sw-1:0] r_idx, w_idx_nxt, r_last, w_last_nxt, w_size;
   logic [Fw-1:0] r_flit, w_flit;
   logic r_we, w_we, r_ack, w_ack, r_done, w_done;
   logic [V-1:0] w_dec, w_inc;
   logic [Fpay-1:0] w_head_pay;
   assign w_head_pay = Fpay'({pck_class, pck_dest_y, pck_dest_x, current_y, current_x});
   assign w_size = (pck_size < Sw'(2)) ? Sw'(2) : (pck_size > Sw'(MAX_PCK_SIZE)) ? Sw'(MAX_PCK_SIZE) : pck_size;
   assign pck_ack = r_ack;
   assign pck_done = r_done;
   assign flit_out = r_flit;
   assign flit_out_we = r_we;
   // lowest-index VC that still has a credit
   always_comb begin
      w_sel = '0;
      w_any = 1'b0;
      for (int i = V - 1; i >= 0; i--) begin
         if (r_cnt[i] != '0) begin
            w_sel = Vw'(i);
            w_any = 1'b1;
         end
      end
   end
   always_comb begin
      w_state_nxt = r_state;
      w_vc_nxt = r_vc;
      w_idx_nxt = r_idx;
      w_last_nxt = r_last;
      w_flit = r_flit;
      w_we = 1'b0;
      w_ack = 1'b0;
      w_done = 1'b0;
      if (r_state == IDLE) begin
         if (pck_req && w_any) begin
            w_state_nxt = SEND;
            w_vc_nxt = w_sel;
            w_idx_nxt = Sw'(1);
            w_last_nxt = w_size - Sw'(1);
            w_flit = {2'b10, V'(1) << w_sel, w_head_pay};
            w_we = 1'b1;
            w_ack = 1'b1;
         end
      end else if (r_cnt[r_vc] != '0) begin
         w_we = 1'b1;
         w_flit = {1'b0, r_idx == r_last, V'(1) << r_vc, Fpay'(r_idx)};
         w_done = (r_idx == r_last);
         w_state_nxt = w_done ? IDLE : SEND;
         w_idx_nxt = w_done ? '0 : r_idx + Sw'(1);
      end
   end
   // a credit returned to an already-full counter is a protocol error and is dropped
   always_comb begin
      for (int i = 0; i < V; i++) begin
         w_dec[i] = w_we && (w_vc_nxt == Vw'(i));
         w_inc[i] = credit_in[i] && (r_cnt[i] != CNTw'(B));
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vc <= '0;
         r_idx <= '0;
         r_last <= '0;
         r_flit <= '0;
         r_we <= 1'b0;
         r_ack <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_vc <= w_vc_nxt;
         r_idx <= w_idx_nxt;
         r_last <= w_last_nxt;
         r_flit <= w_flit;
         r_we <= w_we;
         r_ack <= w_ack;
         r_done <= w_done;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      for (int i = 0; i < V; i++) begin
         if (reset) r_cnt[i] <= CNTw'(B);
         else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNTw'(1);
         else if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNTw'(1);
      end
   end
`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < V; i++) begin
            assert (!(credit_in[i] && r_cnt[i] == CNTw'(B)))
            else $error("credit overflow on VC %0d", i);
         end
      end
   end
`endif
endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: directed steps with hand-computed flits for ni_flit_injector (default parameters).
module tb_ni_flit_injector;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [2:0] current_x = 3'd1;
   logic [2:0] current_y = 3'd2;
   logic pck_req;
   logic [2:0] pck_dest_x, pck_dest_y;
   logic pck_class;
   logic [4:0] pck_size;
   logic pck_ack, pck_done, flit_out_we;
   logic [37:0] flit_out;
   logic [3:0] credit_in;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   ni_flit_injector dut (
      .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
      .pck_req(pck_req), .pck_dest_x(pck_dest_x), .pck_dest_y(pck_dest_y),
      .pck_class(pck_class), .pck_size(pck_size), .pck_ack(pck_ack),
      .pck_done(pck_done), .flit_out(flit_out), .flit_out_we(flit_out_we),
      .credit_in(credit_in)
   );
   function automatic logic [37:0] fl(input logic h, input logic t, input logic [3:0] vc, input logic [31:0] p);
      return {h, t, vc, p};
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic we, input logic ack, input logic done, input logic [37:0] f);
      checks++;
      assert ({flit_out_we, pck_ack, pck_done, flit_out} === {we, ack, done, f})
      else begin
         errors++;
         $error("FAIL %s got we=%b ack=%b done=%b flit=%h exp we=%b ack=%b done=%b flit=%h",
                tag, flit_out_we, pck_ack, pck_done, flit_out, we, ack, done, f);
      end
   endtask
   initial begin
      pck_req = 1'b0;
      pck_dest_x = '0;
      pck_dest_y = '0;
      pck_class = 1'b0;
      pck_size = '0;
      credit_in = '0;
      #1 reset = 1'b1;
      #2 chk("reset_hold", 0, 0, 0, '0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", 0, 0, 0, '0);
      end
      // size-2 packet from (1,2) to (3,0), class 1
      pck_req = 1'b1; pck_dest_x = 3'd3; pck_dest_y = 3'd0; pck_class = 1'b1; pck_size = 5'd2;
      tick(); chk("head_vc0", 1, 1, 0, fl(1, 0, 4'b0001, 32'h10D1));
      pck_req = 1'b0;
      tick(); chk("tail_size2", 1, 0, 1, fl(0, 1, 4'b0001, 32'd1));
      credit_in = 4'b0001;
      tick(); chk("hold_credit_a", 0, 0, 0, fl(0, 1, 4'b0001, 32'd1));
      tick(); chk("hold_credit_b", 0, 0, 0, fl(0, 1, 4'b0001, 32'd1));
      credit_in = '0;
      // size-6 packet stalls after the four initial credits
      pck_req = 1'b1; pck_size = 5'd6;
      tick(); chk("head6", 1, 1, 0, fl(1, 0, 4'b0001, 32'h10D1));
      pck_req = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick(); chk("body6", 1, 0, 0, fl(0, 0, 4'b0001, i));
      end
      tick(); chk("stall_a", 0, 0, 0, fl(0, 0, 4'b0001, 32'd3));
      tick(); chk("stall_b", 0, 0, 0, fl(0, 0, 4'b0001, 32'd3));
      credit_in = 4'b0001;
      tick(); chk("stall_credit1", 0, 0, 0, fl(0, 0, 4'b0001, 32'd3));
      credit_in = '0;
      tick(); chk("flit4", 1, 0, 0, fl(0, 0, 4'b0001, 32'd4));
      credit_in = 4'b0001;
      tick(); chk("stall_credit2", 0, 0, 0, fl(0, 0, 4'b0001, 32'd4));
      credit_in = '0;
      tick(); chk("tail5", 1, 0, 1, fl(0, 1, 4'b0001, 32'd5));
      // VC0 exhausted: next packet goes to VC1
      pck_req = 1'b1; pck_dest_x = 3'd5; pck_dest_y = 3'd7; pck_class = 1'b0; pck_size = 5'd2;
      tick(); chk("head_vc1", 1, 1, 0, fl(1, 0, 4'b0010, 32'hF51));
      pck_req = 1'b0;
      tick(); chk("tail_vc1", 1, 0, 1, fl(0, 1, 4'b0010, 32'd1));
      // credit and send on VC0 in the same cycle leave its counter at 1
      credit_in = 4'b0001;
      tick(); chk("credit_idle", 0, 0, 0, fl(0, 1, 4'b0010, 32'd1));
      pck_req = 1'b1; pck_dest_x = 3'd3; pck_dest_y = 3'd0; pck_class = 1'b1; pck_size = 5'd3;
      tick(); chk("head_cr", 1, 1, 0, fl(1, 0, 4'b0001, 32'h10D1));
      pck_size = 5'd5;
      tick(); chk("body_cr", 1, 0, 0, fl(0, 0, 4'b0001, 32'd1));
      credit_in = '0;
      tick(); chk("tail_cr", 1, 0, 1, fl(0, 1, 4'b0001, 32'd2));
      tick(); chk("b2b_head_vc1", 1, 1, 0, fl(1, 0, 4'b0010, 32'h10D1));
      pck_req = 1'b0;
      tick(); chk("b2b_body_vc1", 1, 0, 0, fl(0, 0, 4'b0010, 32'd1));
      tick(); chk("vc1_stall", 0, 0, 0, fl(0, 0, 4'b0010, 32'd1));
      // abort mid-packet
      reset = 1'b1;
      #1 chk("reset_async", 0, 0, 0, '0);
      @(negedge clk);
      reset = 1'b0;
      pck_req = 1'b1; pck_size = 5'd5;
      tick(); chk("head_after_rst", 1, 1, 0, fl(1, 0, 4'b0001, 32'h10D1));
      pck_req = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick(); chk("body_after_rst", 1, 0, 0, fl(0, 0, 4'b0001, i));
      end
      tick(); chk("stall_after_rst", 0, 0, 0, fl(0, 0, 4'b0001, 32'd3));
      credit_in = 4'b0001;
      tick(); chk("stall_after_rst_cr", 0, 0, 0, fl(0, 0, 4'b0001, 32'd3));
      credit_in = '0;
      tick(); chk("tail_after_rst", 1, 0, 1, fl(0, 1, 4'b0001, 32'd4));
      // size 0 is treated as 2
      pck_req = 1'b1; pck_dest_x = 3'd5; pck_dest_y = 3'd7; pck_class = 1'b0; pck_size = 5'd0;
      tick(); chk("head_size0", 1, 1, 0, fl(1, 0, 4'b0010, 32'hF51));
      pck_req = 1'b0;
      tick(); chk("tail_size0", 1, 0, 1, fl(0, 1, 4'b0010, 32'd1));
      tick(); chk("idle_end", 0, 0, 0, fl(0, 1, 4'b0010, 32'd1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
